// File: rtl/renas_mem_pkg.sv
// Shared types for the three-way SRAM arbiter: FSM states, grant codes and
// the latched request record, plus the address legality check.
package renas_mem_pkg;

  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_WB, GNT_D, GNT_I} grant_e;

  typedef struct packed {
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } req_t;

  // Misaligned byte address, or word index past the end of the SRAM.
  function automatic logic addr_bad(input logic [REQ_ADDR_W-1:0] addr,
                                    input int unsigned depth);
    return (addr[1:0] != 2'b00) ||
           ({2'b00, addr[REQ_ADDR_W-1:2]} >= REQ_ADDR_W'(depth));
  endfunction

endpackage

// File: rtl/renas_mem_age_cnt.sv
// Saturating wait-age counter for the write-buffer drain request; urgent
// goes high once the request has waited AGE_MAX cycles without a grant.
module renas_mem_age_cnt #(
  parameter int AGE_MAX = 8,
  parameter int AW      = $clog2(AGE_MAX + 1)
) (
  input  logic clk_l2,
  input  logic rst,
  input  logic req,
  input  logic clear,
  output logic urgent
);

  logic [AW-1:0] age_reg;

  always_ff @(posedge clk_l2) begin
    if (rst) begin
      age_reg <= '0;
    end else if (clear || !req) begin
      age_reg <= '0;
    end else if (age_reg != AW'(AGE_MAX)) begin
      age_reg <= age_reg + 1'b1;
    end
  end

  assign urgent = (age_reg == AW'(AGE_MAX));

endmodule

// File: rtl/renas_mem_arbiter.sv
// Single-port SRAM sequencer shared by I-fetch, D load/store and WB drain.
// One access in flight; D/I round-robin, WB opportunistic or promoted by age/full.
module renas_mem_arbiter
  import renas_mem_pkg::*;
#(
  parameter int ADDR_W     = REQ_ADDR_W,
  parameter int DATA_W     = REQ_DATA_W,
  parameter int MEM_DEPTH  = 4096,
  parameter int READ_LAT   = 1,
  parameter int WB_AGE_MAX = 8
) (
  input  logic                         clk_l2,
  input  logic                         rst,
  input  logic                         i_req,
  input  logic [ADDR_W-1:0]            i_addr,
  output logic                         i_ack,
  output logic [DATA_W-1:0]            i_rdata,
  output logic                         i_err,
  input  logic                         d_req,
  input  logic                         d_we,
  input  logic [ADDR_W-1:0]            d_addr,
  input  logic [DATA_W-1:0]            d_wdata,
  output logic                         d_ack,
  output logic [DATA_W-1:0]            d_rdata,
  output logic                         d_err,
  input  logic                         wb_req,
  input  logic                         wb_full,
  input  logic [ADDR_W-1:0]            wb_addr,
  input  logic [DATA_W-1:0]            wb_wdata,
  output logic                         wb_ack,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic                         busy
);

  localparam int MEM_AW = $clog2(MEM_DEPTH);
  localparam int LAT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  arb_state_e        state_reg, state_next;
  grant_e            gnt_reg, gnt_next;
  req_t              req_reg, req_next;
  logic              err_reg, err_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              rr_last_d_reg, rr_last_d_next;
  logic [LAT_W-1:0]  lat_reg, lat_next;

  grant_e            win;
  req_t              win_req;
  logic              win_bad;
  logic              wb_urgent;
  logic              wb_clear;

  // While busy, WB counts as granted for its whole transaction so it does not age.
  assign wb_clear = (state_reg == IDLE) ? (win == GNT_WB) : (gnt_reg == GNT_WB);

  renas_mem_age_cnt #(
    .AGE_MAX (WB_AGE_MAX)
  ) u_age_cnt (
    .clk_l2 (clk_l2),
    .rst    (rst),
    .req    (wb_req),
    .clear  (wb_clear),
    .urgent (wb_urgent)
  );

  always_comb begin
    win     = GNT_NONE;
    win_req = '0;
    if (wb_req && (wb_full || wb_urgent)) begin
      win = GNT_WB;
    end else if (d_req && i_req) begin
      win = rr_last_d_reg ? GNT_I : GNT_D;
    end else if (d_req) begin
      win = GNT_D;
    end else if (i_req) begin
      win = GNT_I;
    end else if (wb_req) begin
      win = GNT_WB;
    end

    case (win)
      GNT_WB: begin
        win_req.we    = 1'b1;
        win_req.addr  = wb_addr;
        win_req.wdata = wb_wdata;
      end
      GNT_D: begin
        win_req.we    = d_we;
        win_req.addr  = d_addr;
        win_req.wdata = d_wdata;
      end
      GNT_I: begin
        win_req.addr  = i_addr;
      end
      default: win_req = '0;
    endcase
    win_bad = addr_bad(win_req.addr, MEM_DEPTH);
  end

  always_comb begin
    state_next     = state_reg;
    gnt_next       = gnt_reg;
    req_next       = req_reg;
    err_next       = err_reg;
    rdata_next     = rdata_reg;
    rr_last_d_next = rr_last_d_reg;
    lat_next       = lat_reg;

    case (state_reg)
      IDLE: begin
        if (win != GNT_NONE) begin
          gnt_next   = win;
          req_next   = win_req;
          err_next   = win_bad;
          lat_next   = '0;
          // Stores echo their data; loads are filled in WAIT; errors return zero.
          rdata_next = (win == GNT_D && d_we && !win_bad) ? d_wdata : '0;
          if (!win_bad && (win == GNT_D || win == GNT_I)) begin
            rr_last_d_next = (win == GNT_D);
          end
          state_next = win_bad ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        lat_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (lat_reg == LAT_W'(READ_LAT - 1)) begin
          if (!req_reg.we) begin
            rdata_next = mem_rdata;
          end
          state_next = RESP;
        end else begin
          lat_next = lat_reg + 1'b1;
        end
      end
      RESP: begin
        gnt_next   = GNT_NONE;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_l2) begin
    if (rst) begin
      state_reg     <= IDLE;
      gnt_reg       <= GNT_NONE;
      req_reg       <= '0;
      err_reg       <= 1'b0;
      rdata_reg     <= '0;
      rr_last_d_reg <= 1'b0;
      lat_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      gnt_reg       <= gnt_next;
      req_reg       <= req_next;
      err_reg       <= err_next;
      rdata_reg     <= rdata_next;
      rr_last_d_reg <= rr_last_d_next;
      lat_reg       <= lat_next;
    end
  end

  assign busy      = (state_reg != IDLE);
  assign mem_en    = (state_reg == ISSUE);
  assign mem_we    = mem_en && req_reg.we;
  assign mem_addr  = req_reg.addr[MEM_AW+1:2];
  assign mem_wdata = req_reg.wdata;

  assign i_ack   = (state_reg == RESP) && (gnt_reg == GNT_I);
  assign d_ack   = (state_reg == RESP) && (gnt_reg == GNT_D);
  assign wb_ack  = (state_reg == RESP) && (gnt_reg == GNT_WB);
  assign i_err   = i_ack && err_reg;
  assign d_err   = d_ack && err_reg;
  assign i_rdata = i_ack ? rdata_reg : '0;
  assign d_rdata = d_ack ? rdata_reg : '0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_reg.addr[ADDR_W-1:MEM_AW+2], req_reg.addr[1:0]};

endmodule

// File: tb/tb_renas_mem_arbiter.sv
// Scoreboard bench for renas_mem_arbiter: expected acks are queued as
// requests are raised and matched against each ack the DUT produces.
module tb_renas_mem_arbiter;

  localparam int P_WB = 1;
  localparam int P_D  = 2;
  localparam int P_I  = 3;

  logic        clk_l2 = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, wb_req, wb_full;
  logic [31:0] i_addr, d_addr, d_wdata, wb_addr, wb_wdata;
  logic        i_ack, i_err, d_ack, d_err, wb_ack;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_en, mem_we, busy;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk_l2 = ~clk_l2;

  renas_mem_arbiter dut (
    .clk_l2(clk_l2), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .wb_req(wb_req), .wb_full(wb_full), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
    .wb_ack(wb_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  logic [31:0] sram [0:4095];
  always @(posedge clk_l2) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   ack_cnt = 0;
  int   en_count = 0;
  int   en_cyc = 0;
  int   ack_cyc = 0;
  int   t0, e0;

  always @(posedge clk_l2) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic push(input int port, input logic [31:0] data, input logic err);
    sb.push_back('{port: port, data: data, err: err});
  endtask

  always @(negedge clk_l2) begin
    exp_t e;
    int   port;
    if (mem_en) begin
      en_count++;
      en_cyc = cyc;
    end
    if (i_ack || d_ack || wb_ack) begin
      ack_cyc = cyc;
      ack_cnt++;
      if ((32'(i_ack) + 32'(d_ack) + 32'(wb_ack)) != 1) chk("one_hot_ack", 0, 1);
      port = wb_ack ? P_WB : (d_ack ? P_D : P_I);
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(port), 0);
      end else begin
        e = sb.pop_front();
        chk("ack_port", 32'(port), 32'(e.port));
        if (port == P_D) begin
          chk("d_rdata", d_rdata, e.data);
          chk("d_err", 32'(d_err), 32'(e.err));
        end else if (port == P_I) begin
          chk("i_rdata", i_rdata, e.data);
          chk("i_err", 32'(i_err), 32'(e.err));
        end
        $display("ack cyc=%0d port=%0d d_rdata=%0h i_rdata=%0h err=%0b",
                 cyc, port, d_rdata, i_rdata, d_err | i_err);
      end
    end
  end

  task automatic drop_all();
    i_req = 0; d_req = 0; wb_req = 0; wb_full = 0;
  endtask

  task automatic run_until(input int k);
    int target = ack_cnt + k;
    int budget = 300;
    while (ack_cnt < target && budget > 0) begin
      @(posedge clk_l2);
      budget--;
    end
    if (budget == 0) chk("ack_timeout", 32'(ack_cnt), 32'(target));
    #1;
    drop_all();
  endtask

  task automatic start();
    @(posedge clk_l2);
    #1;
    t0 = cyc;
    e0 = en_count;
  endtask

  task automatic do_reset();
    @(posedge clk_l2);
    #1 rst = 1;
    repeat (2) @(posedge clk_l2);
    #1 rst = 0;
  endtask

  initial begin
    rst = 1; drop_all(); d_we = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; wb_addr = 0; wb_wdata = 0;
    repeat (3) @(posedge clk_l2);
    #1 rst = 0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_en", 32'({mem_en, mem_we}), 0);
    chk("rst_acks", 32'({i_ack, d_ack, wb_ack}), 0);
    chk("rst_errs", 32'({i_err, d_err}), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", i_rdata | d_rdata, 0);

    // WB write seeds MEM[5], then a lone I read checks latency and data.
    start(); wb_req = 1; wb_addr = 32'h14; wb_wdata = 32'hDEAD_BEEF;
    push(P_WB, 0, 0); run_until(1);
    start(); i_req = 1; i_addr = 32'h14;
    push(P_I, 32'hDEAD_BEEF, 0); run_until(1);
    chk("i_en_lat", 32'(en_cyc - t0), 1);
    chk("i_ack_lat", 32'(ack_cyc - t0), 3);
    chk("i_en_count", 32'(en_count - e0), 1);

    start(); d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h1234_5678;
    push(P_D, 32'h1234_5678, 0); run_until(1);
    start(); d_req = 1; d_we = 0; d_addr = 32'h20; d_wdata = 0;
    push(P_D, 32'h1234_5678, 0); run_until(1);

    // D and I held together alternate starting with D after reset.
    do_reset();
    start(); d_req = 1; d_we = 0; d_addr = 32'h20; i_req = 1; i_addr = 32'h14;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) push(P_D, 32'h1234_5678, 0);
      else            push(P_I, 32'hDEAD_BEEF, 0);
    end
    run_until(8);

    // WB waiting behind D/I: age hits 8 at the third IDLE.
    do_reset();
    start(); d_req = 1; d_we = 0; d_addr = 32'h20; i_req = 1; i_addr = 32'h14;
    wb_req = 1; wb_addr = 32'h30; wb_wdata = 32'hA5A5_A5A5;
    push(P_D, 32'h1234_5678, 0); push(P_I, 32'hDEAD_BEEF, 0); push(P_WB, 0, 0);
    run_until(3);
    start(); d_req = 1; d_we = 0; d_addr = 32'h30;
    push(P_D, 32'hA5A5_A5A5, 0); run_until(1);

    do_reset();
    start(); d_req = 1; d_we = 0; d_addr = 32'h20; i_req = 1; i_addr = 32'h14;
    wb_req = 1; wb_full = 1; wb_addr = 32'h34; wb_wdata = 32'h5A5A_5A5A;
    push(P_WB, 0, 0); run_until(1);
    start(); d_req = 1; d_we = 0; d_addr = 32'h34;
    push(P_D, 32'h5A5A_5A5A, 0); run_until(1);

    start(); d_req = 1; d_we = 0; d_addr = 32'h22;
    push(P_D, 0, 1); run_until(1);
    chk("err_misalign_no_en", 32'(en_count - e0), 0);
    chk("err_ack_lat", 32'(ack_cyc - t0), 1);
    start(); d_req = 1; d_we = 1; d_addr = 32'h4000; d_wdata = 32'hFFFF_FFFF;
    push(P_D, 0, 1); run_until(1);
    chk("err_range_no_en", 32'(en_count - e0), 0);

    // Reset during WAIT drops the access; the held request is served again.
    start(); i_req = 1; i_addr = 32'h14;
    @(posedge clk_l2); #1;
    @(posedge clk_l2); #1;
    chk("wait_busy", 32'(busy), 1);
    rst = 1;
    @(posedge clk_l2); #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_mem_en", 32'(mem_en), 0);
    chk("midrst_ack", 32'({i_ack, d_ack, wb_ack}), 0);
    chk("midrst_en_count", 32'(en_count - e0), 1);
    rst = 0;
    push(P_I, 32'hDEAD_BEEF, 0); run_until(1);
    chk("reserve_en_count", 32'(en_count - e0), 2);
    chk("reserve_ack_lat", 32'(ack_cyc - t0), 6);

    repeat (3) @(posedge clk_l2);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
